// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2-to-Hack keyboard front end.
package ps2_pkg;

  localparam int HACK_W = 8;
  localparam int KBD_W  = 16;

  localparam logic [HACK_W-1:0] HACK_NEWLINE   = 8'd128;
  localparam logic [HACK_W-1:0] HACK_BACKSPACE = 8'd129;
  localparam logic [HACK_W-1:0] HACK_LEFT      = 8'd130;

  typedef struct packed {
    logic              pressed;
    logic [HACK_W-1:0] code;
  } hack_evt_t;

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word-fall-through FIFO of key events; the head is read combinationally
// from the registered memory so it is visible the cycle after it is written.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  hack_evt_t                i_wr_data,
  input  logic                     i_pop,
  output hack_evt_t                o_rd_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  hack_evt_t   r_mem [DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        w_wr_en;
  logic        w_rd_en;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_count = r_wptr - r_rptr;

  assign w_rd_en = i_pop && !o_empty;
  // A write while full is only legal when the head slot is vacated this edge.
  assign w_wr_en = i_push && (!o_full || w_rd_en);

  assign o_rd_data = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wptr[AW-1:0]] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr_en) r_wptr <= r_wptr + 1'b1;
      if (w_rd_en) r_rptr <= r_rptr + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_hack_kbd.sv
// Hack keyboard front end: held-key register, repeat filter, event FIFO and
// sticky overflow flag.
module ps2_hack_kbd
  import ps2_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int REPEAT_EN = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [HACK_W-1:0]      hack,
  input  logic                   hack_valid,
  input  logic                   pressed,
  output logic [KBD_W-1:0]       kbd,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [HACK_W-1:0]      evt_code,
  output logic                   evt_pressed,
  output logic [$clog2(DEPTH):0] evt_count,
  output logic                   overflow,
  input  logic                   clr_overflow
);

  logic [HACK_W-1:0] r_held;
  logic              r_overflow;
  logic              w_event;
  logic              w_repeat;
  logic              w_accept;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_drop;
  hack_evt_t         w_wr_evt;
  hack_evt_t         w_head;

  assign w_event  = hack_valid && (hack != '0);
  assign w_repeat = pressed && (r_held != '0) && (hack == r_held);
  assign w_accept = w_event && !(w_repeat && (REPEAT_EN == 0));
  assign w_pop    = !w_empty && evt_ready;
  assign w_drop   = w_accept && w_full && !w_pop;

  assign w_wr_evt.pressed = pressed;
  assign w_wr_evt.code    = hack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_held <= '0;
    end else if (w_event) begin
      if (pressed) begin
        r_held <= hack;
      end else if (hack == r_held) begin
        r_held <= '0;
      end
    end
  end

  // A drop in the same cycle as a clear leaves the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clr_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  ps2_event_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_accept),
    .i_wr_data (w_wr_evt),
    .i_pop     (w_pop),
    .o_rd_data (w_head),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (evt_count)
  );

  assign kbd         = {{(KBD_W-HACK_W){1'b0}}, r_held};
  assign evt_valid   = !w_empty;
  assign evt_code    = w_head.code;
  assign evt_pressed = w_head.pressed;
  assign overflow    = r_overflow;

endmodule
